// File: rtl/bram_burst_master_pkg.sv
// Shared encodings for the block-RAM burst master and its response buffer.
package bram_burst_master_pkg;

    typedef enum logic [1:0] {
        CMD_READ     = 2'b00,
        CMD_WRITE    = 2'b01,
        CMD_EXCHANGE = 2'b10,
        CMD_RSVD     = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int RSP_DEPTH = 2;

    function automatic logic cmd_has_wdata(input cmd_e c);
        return (c == CMD_WRITE) || (c == CMD_EXCHANGE);
    endfunction

    function automatic logic cmd_has_rsp(input cmd_e c);
        return (c != CMD_WRITE);
    endfunction

endpackage

// File: rtl/bram_rsp_fifo2.sv
// Two-entry response FIFO (data + last tag) with occupancy output.
module bram_rsp_fifo2
    import bram_burst_master_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last,
    output logic [1:0]   count
);

    logic [W-1:0] mem_data [RSP_DEPTH];
    logic         mem_last [RSP_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop & (occ != 2'd0);
    assign push_ok = push & ((occ != 2'(RSP_DEPTH)) | pop_ok);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Head is masked when empty so stale entries never leak onto rdata.
    assign valid = (occ != 2'd0);
    assign data  = valid ? mem_data[rd_ptr] : '0;
    assign last  = valid & mem_last[rd_ptr];
    assign count = occ;

endmodule

// File: rtl/bram_burst_master.sv
// Burst initiator for the single-port, byte-lane, read-first block RAM.
// state | meaning
// IDLE  | req_ready high, waiting for a command
// BURST | issuing beats until the beat with counter == len
module bram_burst_master
    import bram_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DI_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_cmd,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LEN_WIDTH-1:0]    req_len,
    input  logic [1:0]              req_be,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [2*DI_WIDTH-1:0]   wdata,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [2*DI_WIDTH-1:0]   rdata,
    output logic                    rdata_last,
    output logic [1:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [2*DI_WIDTH-1:0]   ram_di,
    input  logic [2*DI_WIDTH-1:0]   ram_do
);

    localparam int DW = 2 * DI_WIDTH;

    state_e                 state_q;
    state_e                 state_d;
    cmd_e                   cmd_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [1:0]             be_q;
    logic                   inflight_q;
    logic                   inflight_last_q;

    logic [1:0]             rsp_count;
    logic                   pop;
    logic [2:0]             pending;
    logic                   credit;
    logic                   issue;
    logic                   last_beat;
    logic                   accept;

    assign pop       = rdata_valid & rdata_ready;
    assign pending   = {1'b0, rsp_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit    = (pending < 3'(RSP_DEPTH));
    assign last_beat = (cnt_q == len_q);
    assign accept    = (state_q == IDLE) & req_valid;

    always_comb begin
        issue = 1'b0;
        if (state_q == BURST) begin
            case (cmd_q)
                CMD_WRITE:    issue = wdata_valid;
                CMD_EXCHANGE: issue = wdata_valid & credit;
                default:      issue = credit;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)          state_d = BURST;
            BURST:   if (issue && last_beat) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        wdata_ready = issue & cmd_has_wdata(cmd_q);
        ram_we      = (issue && cmd_has_wdata(cmd_q)) ? be_q : 2'b00;
        ram_addr    = addr_q;
        ram_di      = wdata;
    end

    // Reserved encoding is folded into READ at accept so the burst logic sees three commands.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cmd_q           <= CMD_READ;
            addr_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            be_q            <= 2'b00;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q  <= (cmd_e'(req_cmd) == CMD_RSVD) ? CMD_READ : cmd_e'(req_cmd);
                addr_q <= req_addr;
                len_q  <= req_len;
                be_q   <= req_be;
                cnt_q  <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                cnt_q  <= cnt_q + LEN_WIDTH'(1);
            end
            inflight_q      <= issue & cmd_has_rsp(cmd_q);
            inflight_last_q <= issue & last_beat;
        end
    end

    bram_rsp_fifo2 #(
        .W (DW)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (inflight_q),
        .push_data (ram_do),
        .push_last (inflight_last_q),
        .pop       (pop),
        .valid     (rdata_valid),
        .data      (rdata),
        .last      (rdata_last),
        .count     (rsp_count)
    );

endmodule

// File: tb/tb_bram_burst_master.sv
// Bench for bram_burst_master against a behavioural read-first byte-lane RAM.
module tb_bram_burst_master;
    import bram_burst_master_pkg::*;

    localparam int AW  = 9;
    localparam int DIW = 8;
    localparam int LW  = 8;
    localparam int DW  = 2 * DIW;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_cmd;
    logic [AW-1:0]  req_addr;
    logic [LW-1:0]  req_len;
    logic [1:0]     req_be;
    logic           wdata_valid;
    logic           wdata_ready;
    logic [DW-1:0]  wdata;
    logic           rdata_valid;
    logic           rdata_ready;
    logic [DW-1:0]  rdata;
    logic           rdata_last;
    logic [1:0]     ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_di;
    logic [DW-1:0]  ram_do;

    always #5 CLK = ~CLK;

    bram_burst_master #(
        .ADDR_WIDTH (AW),
        .DI_WIDTH   (DIW),
        .LEN_WIDTH  (LW)
    ) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_be      (req_be),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_do      (ram_do)
    );

    // Read-first RAM: DO shows the pre-write word one cycle after the access.
    logic [DW-1:0] mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    always @(posedge CLK) begin
        ram_do <= mem[ram_addr];
        if (ram_we[0]) mem[ram_addr][DIW-1:0]    <= ram_di[DIW-1:0];
        if (ram_we[1]) mem[ram_addr][DW-1:DIW]   <= ram_di[DW-1:DIW];
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rsp_t;

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [1:0]    be;
        logic [DW-1:0] wd;
        logic          has_rsp;
        logic [DW-1:0] exp;
    } vec_t;

    rsp_t          sb [$];
    logic [DW-1:0] wbuf [16];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_rsp(input logic [DW-1:0] d, input logic l);
        rsp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        rsp_t e;
        if (RST_N && rdata_valid && rdata_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got 0x%0h expected none", rdata);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rdata), 32'(e.data));
                check("rsp_last", 32'(rdata_last), 32'(e.last));
            end
        end
    end

    task automatic send_req(input logic [1:0] cmd, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [1:0] be);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_len   = len;
        req_be    = be;
        @(negedge CLK);
        while (!req_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) timeout("req_handshake");
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            wdata_valid = 1'b1;
            wdata       = wbuf[i];
            @(negedge CLK);
            while (!wdata_ready && t < 200) begin
                @(negedge CLK);
                t++;
            end
            check("wdata_ready", 32'(wdata_ready), 32'd1);
            tick();
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge CLK);
        while (!(req_ready && sb.size() == 0 && !rdata_valid) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!(req_ready && sb.size() == 0 && !rdata_valid)) timeout("drain");
        tick();
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, input logic [1:0] be);
        send_req(cmd, addr, len, be);
        if (cmd == CMD_WRITE || cmd == CMD_EXCHANGE) feed(int'(len) + 1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt [13];
        logic [AW-1:0] wrap_addr [4];

        vt[0]  = '{2'b01, 9'h020, 2'b11, 16'hAABB, 1'b0, 16'h0000};
        vt[1]  = '{2'b01, 9'h020, 2'b01, 16'h00CC, 1'b0, 16'h0000};
        vt[2]  = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'hAACC};
        vt[3]  = '{2'b01, 9'h020, 2'b10, 16'hDD00, 1'b0, 16'h0000};
        vt[4]  = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'hDDCC};
        vt[5]  = '{2'b10, 9'h020, 2'b11, 16'h1234, 1'b1, 16'hDDCC};
        vt[6]  = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'h1234};
        vt[7]  = '{2'b01, 9'h020, 2'b00, 16'hFFFF, 1'b0, 16'h0000};
        vt[8]  = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'h1234};
        vt[9]  = '{2'b10, 9'h020, 2'b01, 16'h5678, 1'b1, 16'h1234};
        vt[10] = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'h1278};
        vt[11] = '{2'b11, 9'h020, 2'b11, 16'hFFFF, 1'b1, 16'h1278};
        vt[12] = '{2'b00, 9'h020, 2'b00, 16'h0000, 1'b1, 16'h1278};

        wrap_addr[0] = 9'h1FE;
        wrap_addr[1] = 9'h1FF;
        wrap_addr[2] = 9'h000;
        wrap_addr[3] = 9'h001;

        RST_N       = 1'b0;
        req_valid   = 1'b0;
        req_cmd     = 2'b00;
        req_addr    = '0;
        req_len     = '0;
        req_be      = 2'b00;
        wdata_valid = 1'b1;
        wdata       = 16'hFFFF;
        rdata_ready = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready",   32'(req_ready),   32'd1);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata_last",  32'(rdata_last),  32'd0);
        check("rst_rdata",       32'(rdata),       32'd0);
        check("rst_ram_we",      32'(ram_we),      32'd0);
        tick();
        RST_N       = 1'b1;
        wdata_valid = 1'b0;
        tick();

        // Back-to-back write burst then read burst with latency and throughput checks.
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        run_op(CMD_WRITE, 9'h010, 8'd3, 2'b11);
        for (int i = 0; i < 4; i++) expect_rsp(wbuf[i], i == 3);
        send_req(CMD_READ, 9'h010, 8'd3, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check($sformatf("lat_valid_%0d", k), 32'(rdata_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check($sformatf("lat_last_%0d", k), 32'(rdata_last), (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        wait_done();

        for (int i = 0; i < 13; i++) begin
            if (vt[i].has_rsp) expect_rsp(vt[i].exp, 1'b1);
            wbuf[0] = vt[i].wd;
            run_op(vt[i].cmd, vt[i].addr, 8'd0, vt[i].be);
        end

        // Address wrap at the top of the RAM.
        wbuf[0] = 16'hC001; wbuf[1] = 16'hC002; wbuf[2] = 16'hC003; wbuf[3] = 16'hC004;
        run_op(CMD_WRITE, 9'h1FE, 8'd3, 2'b11);
        for (int i = 0; i < 4; i++) expect_rsp(wbuf[i], i == 3);
        send_req(CMD_READ, 9'h1FE, 8'd3, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check($sformatf("wrap_addr_%0d", k), 32'(ram_addr), 32'(wrap_addr[k]));
        end
        tick();
        wait_done();

        // Backpressure: three beats issue before the stall, then issue halts at 0x083.
        for (int i = 0; i < 8; i++) wbuf[i] = 16'hB000 + 16'(i);
        run_op(CMD_WRITE, 9'h080, 8'd7, 2'b11);
        for (int i = 0; i < 8; i++) expect_rsp(wbuf[i], i == 7);
        send_req(CMD_READ, 9'h080, 8'd7, 2'b00);
        repeat (3) @(negedge CLK);
        tick();
        rdata_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("bp_valid", 32'(rdata_valid), 32'd1);
            check("bp_occ_le2", 32'(u_dut.rsp_count <= 2'd2), 32'd1);
            check("bp_stall_addr", 32'(ram_addr), 32'h083);
        end
        tick();
        rdata_ready = 1'b1;
        wait_done();

        // Reset asserted while beat 2 of a six-beat write is presented.
        for (int i = 0; i < 6; i++) wbuf[i] = 16'h0000;
        run_op(CMD_WRITE, 9'h040, 8'd5, 2'b11);
        for (int i = 0; i < 6; i++) wbuf[i] = 16'hA000 + 16'(i);
        send_req(CMD_WRITE, 9'h040, 8'd5, 2'b11);
        feed(2);
        wdata_valid = 1'b1;
        wdata       = wbuf[2];
        RST_N       = 1'b0;
        tick();
        @(negedge CLK);
        check("rstmid_ram_we",      32'(ram_we),      32'd0);
        check("rstmid_req_ready",   32'(req_ready),   32'd1);
        check("rstmid_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rstmid_wdata_ready", 32'(wdata_ready), 32'd0);
        tick();
        wdata = wbuf[3];
        @(negedge CLK);
        check("rstmid_ram_we_hold", 32'(ram_we), 32'd0);
        tick();
        RST_N       = 1'b1;
        wdata_valid = 1'b0;
        tick();
        expect_rsp(16'hA000, 1'b0);
        expect_rsp(16'hA001, 1'b0);
        expect_rsp(16'hA002, 1'b0);
        expect_rsp(16'h0000, 1'b0);
        expect_rsp(16'h0000, 1'b0);
        expect_rsp(16'h0000, 1'b1);
        run_op(CMD_READ, 9'h040, 8'd5, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
